// File: rtl/prod_accum.sv
// Burst accumulator for 8-bit unsigned products from the upstream multiplier array.
// Sums len products (0 means 16) and presents the wrapped sum with a sticky carry flag.
module prod_accum #(
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             clear,
  input  logic [3:0]       len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [3:0]       r_rem;
  logic             r_ovf;
  logic             r_out_valid;
  logic [ACC_W:0]   w_sum;

  // Top bit of the result is the carry out of the ACC_W-bit accumulator.
  function automatic logic [ACC_W:0] add_wrap(input logic [ACC_W-1:0] a,
                                              input logic [7:0]       b);
    return (ACC_W+1)'(a) + (ACC_W+1)'(b);
  endfunction

  assign w_sum     = add_wrap(r_acc, in_data);
  assign in_ready  = rst_n & ena & (r_state != S_DONE);
  assign out_valid = r_out_valid;
  assign out_data  = r_acc;
  assign ovf       = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_rem       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (ena) begin
      if (clear) begin
        r_state     <= S_IDLE;
        r_acc       <= '0;
        r_rem       <= '0;
        r_ovf       <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (in_valid) begin
              r_acc <= ACC_W'(in_data);
              // len-1 in four bits gives 15 for len=0, i.e. a 16-product burst.
              r_rem <= len - 4'd1;
              r_ovf <= 1'b0;
              if (len == 4'd1) begin
                r_state     <= S_DONE;
                r_out_valid <= 1'b1;
              end else begin
                r_state <= S_ACCUM;
              end
            end
          end
          S_ACCUM: begin
            if (in_valid) begin
              r_acc <= w_sum[ACC_W-1:0];
              r_ovf <= r_ovf | w_sum[ACC_W];
              r_rem <= r_rem - 4'd1;
              if (r_rem == 4'd1) begin
                r_state     <= S_DONE;
                r_out_valid <= 1'b1;
              end
            end
          end
          S_DONE: begin
            if (out_ready) begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
            end
          end
          default: begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: a 12-bit and an 8-bit instance share all stimulus.
module tb_prod_accum;

  logic        clk = 1'b0;
  logic        rst_n, ena, clear, in_valid, out_ready;
  logic [3:0]  len;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, ovf;
  logic [11:0] out_data;
  logic        in_ready8, out_valid8, ovf8;
  logic [7:0]  out_data8;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  prod_accum #(.ACC_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .ovf(ovf)
  );

  prod_accum #(.ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready8),
    .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; clear = 1'b0; len = 4'd0;
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
    step(2);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Burst of three: 15 + 225 + 9 = 249
    len = 4'd3; in_valid = 1'b1; in_data = 8'd15;
    step();
    in_data = 8'd225;
    step();
    chk("b3_mid_out_valid", out_valid, 0);
    in_data = 8'd9;
    step();
    in_valid = 1'b0;
    chk("b3_out_valid", out_valid, 1);
    chk("b3_out_data", out_data, 249);
    chk("b3_ovf", ovf, 0);
    chk("b3_in_ready_done", in_ready, 0);
    step();
    chk("b3_idle_out_valid", out_valid, 0);
    chk("b3_idle_in_ready", in_ready, 1);

    // Sixteen products of 225: 3600 fits 12 bits, wraps to 16 in 8 bits
    len = 4'd0; in_valid = 1'b1; in_data = 8'd225;
    step(15);
    chk("b16_pre_out_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("b16_out_valid", out_valid, 1);
    chk("b16_out_data", out_data, 3600);
    chk("b16_ovf", ovf, 0);
    chk("b16_w8_out_valid", out_valid8, 1);
    chk("b16_w8_out_data", out_data8, 16);
    chk("b16_w8_ovf", ovf8, 1);
    step();
    chk("b16_idle_out_valid", out_valid, 0);

    // Back-pressure with a single-product burst; in_valid held high is ignored in DONE
    out_ready = 1'b0; len = 4'd1; in_valid = 1'b1; in_data = 8'd42;
    step();
    in_data = 8'd99;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 42);
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_last_out_data", out_data, 42);
    step();
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_data", out_data, 42);

    // Clear after two of four products, then a fresh burst 1 + 2 = 3
    len = 4'd4; in_valid = 1'b1; in_data = 8'd10;
    step();
    in_data = 8'd20;
    step();
    chk("clr_pre_out_data", out_data, 30);
    in_valid = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_acc", out_data, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_in_ready", in_ready, 1);
    len = 4'd2; in_valid = 1'b1; in_data = 8'd1;
    step();
    in_data = 8'd2;
    step();
    in_valid = 1'b0;
    chk("clr_new_out_valid", out_valid, 1);
    chk("clr_new_out_data", out_data, 3);
    step();

    // Asynchronous reset mid-burst, observed between edges
    len = 4'd5; in_valid = 1'b1; in_data = 8'd7;
    step(2);
    chk("arst_pre_out_data", out_data, 14);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_data", out_data, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_ovf", ovf, 0);
    #1 rst_n = 1'b1;
    len = 4'd1; in_data = 8'd7;
    step();
    in_valid = 1'b0;
    chk("arst_new_out_valid", out_valid, 1);
    chk("arst_new_out_data", out_data, 7);
    step();

    // Enable low mid-burst; a len change mid-burst must not shorten it
    len = 4'd4; in_valid = 1'b1; in_data = 8'd5;
    step();
    len = 4'd1; in_data = 8'd6;
    step();
    ena = 1'b0; in_data = 8'd100;
    #1;
    chk("ena_in_ready", in_ready, 0);
    step(3);
    chk("ena_hold_out_data", out_data, 11);
    chk("ena_hold_out_valid", out_valid, 0);
    ena = 1'b1; in_data = 8'd7;
    step();
    chk("ena_resume_out_valid", out_valid, 0);
    in_data = 8'd8;
    step();
    in_valid = 1'b0;
    chk("ena_done_out_valid", out_valid, 1);
    chk("ena_done_out_data", out_data, 26);
    step();
    chk("ena_idle_out_valid", out_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/prod_accum.md
PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 Parameter: ACC_W, 12, accumulator width in bits; legal range 8..16.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port: ena  input  1  global enable; when 0, all state holds and in_ready is 0.
REQ-005 Port: clear  input  1  synchronous abort; returns the block to IDLE and zeroes the accumulator.
REQ-006 Port: len  input  4  number of products per burst, sampled on the first accepted product; 0 means 16.
REQ-007 Port: in_valid  input  1  product on in_data is valid.
REQ-008 Port: in_data  input  8  unsigned 8-bit product from the upstream 4x4 array multiplier.
REQ-009 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-010 Port: out_valid  output  1  burst sum on out_data is valid.
REQ-011 Port: out_ready  input  1  downstream accepts out_data.
REQ-012 Port: out_data  output  ACC_W  accumulated burst sum.
REQ-013 Port: ovf  output  1  sticky flag: a carry out of ACC_W bits occurred during the current burst.

Function
REQ-014 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-015 Handshake: transfers occur only when valid and ready are both 1 on a rising edge, with ena=1.
REQ-016 IDLE: in_ready=1; on accept, acc<=in_data zero-extended, remaining<=len_eff-1, ovf<=0; go to ACCUM, or to DONE if len_eff=1.
REQ-017 ACCUM: in_ready=1; on accept, acc<=(acc+in_data) mod 2^ACC_W, ovf<=ovf|carry, remaining<=remaining-1; go to DONE when the accepted product is the last.
REQ-018 DONE: in_ready=0, out_valid=1, out_data=acc and ovf held stable until accepted; on out_ready, go to IDLE.
REQ-019 out_valid SHALL be asserted in the cycle after the last product is accepted (latency 1), and the transfer MAY complete in that same cycle.
REQ-020 In DONE, in_valid SHALL be ignored; the upstream holds data per the valid/ready protocol.
REQ-021 A burst cannot start in the DONE/IDLE transition cycle; the first product of the next burst is accepted no earlier than the cycle after out_valid drops.
REQ-022 len SHALL be ignored except on the first accept of a burst; a len change mid-burst has no effect.
REQ-023 clear SHALL take priority over every handshake in its cycle; acc, remaining and ovf go to 0, the state goes to IDLE, and any out_valid is dropped without a transfer.
REQ-024 Behaviour when ena=0: no accepts, no state change; out_valid and out_data keep their held values.
REQ-025 With ACC_W=12, 16 products of 225 (sum 3600) SHALL NOT set ovf; the width rule is sum < 2^ACC_W means no overflow.
REQ-026 in_data SHALL be treated as unsigned, and no saturation is applied; out_data is the wrapped sum.

Reset
REQ-027 While rst_n=0: state=IDLE, acc=0, remaining=0, ovf=0, out_valid=0, out_data=0, and in_ready=0 because the block is held in reset.
REQ-028 After rst_n rises, in_ready SHALL be 1 from the first clock edge, provided ena=1.
REQ-029 An asserted rst_n mid-burst SHALL discard the partial sum immediately, without waiting for a clock edge.

Verification
REQ-030 Reset, then len=3 with products 15, 225, 9 held valid with out_ready=1 -> out_valid one cycle after the 3rd accept, out_data=249, ovf=0, return to IDLE.
REQ-031 len=0, 16 products of 225 -> out_data=3600, ovf=0; with ACC_W=8 the same run gives out_data=3600 mod 256=16 and ovf=1.
REQ-032 Back-pressure: len=1 with product 42 and out_ready=0 for 5 cycles -> out_valid and out_data=42 held stable, in_ready=0; then out_ready=1 -> one transfer and return to IDLE.
REQ-033 clear asserted in ACCUM after 2 of 4 products -> next cycle IDLE, acc=0; a new len=2 burst of 1 and 2 -> out_data=3.
REQ-034 rst_n pulsed low asynchronously mid-burst -> all outputs 0 before the next edge; a subsequent len=1 burst of 7 -> out_data=7.
REQ-035 ena=0 for 3 cycles mid-burst with in_valid=1 -> no accepts and no change to acc; on resume the burst completes with the correct sum.
